// File: rtl/mii_gen_defs.sv
// Shared definitions for the MII/GMII frame generator: state encodings,
// framing constants and the byte-wide reflected CRC-32 step.
package mii_gen_defs;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_FCS,
        ST_IFG
    } gen_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic        MODE_MII      = 1'b0;
    localparam logic        MODE_GMII     = 1'b1;

    // One byte of the LSB-first CRC: data enters at bit 0, poly is bit-reversed.
    function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        logic [31:0] poly_r;
        for (int i = 0; i < 32; i++) poly_r[i] = CRC_POLY[31-i];
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
        return c;
    endfunction

endpackage

// File: rtl/mac_crc32_d8.sv
// Byte-wide IEEE 802.3 CRC-32 register; crc_out is the complemented value
// ready to go on the wire least-significant byte first.
module mac_crc32_d8
    import mii_gen_defs::*;
(
    input  logic        Tx_clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] crc;

    always_ff @(posedge Tx_clk or posedge reset) begin
        if (reset)      crc <= CRC_INIT;
        else if (init)  crc <= CRC_INIT;
        else if (en)    crc <= crc32_d8(crc, data);
    end

    assign crc_out = ~crc;

endmodule

// File: rtl/mii_frame_gen.sv
// MII/GMII transmit frame generator: preamble, SFD, counting payload, FCS, IFG.
// Optional MII_GEN_ERR_INJ_EN adds err_inj/err_pos to strobe Tx_er on one payload byte.
module mii_frame_gen
    import mii_gen_defs::*;
#(
    parameter int IFG_BYTES = 12,
    parameter int PRE_BYTES = 7,
    parameter int LEN_W     = 16
) (
    input  logic             Tx_clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             start,
    input  logic [LEN_W-1:0] frm_len,
    input  logic [LEN_W-1:0] frm_num,
    input  logic [7:0]       pat_seed,
`ifdef MII_GEN_ERR_INJ_EN
    input  logic             err_inj,
    input  logic [LEN_W-1:0] err_pos,
`endif
    output logic             Tx_en,
    output logic             Tx_er,
    output logic [7:0]       Txd,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] frm_cnt
);

    gen_state_t       state, state_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic [LEN_W-1:0] frm_cnt_nxt;
    logic             done_nxt;
    logic             nib;
    logic             mode_r;
    logic [LEN_W-1:0] len_r, num_r;
    logic [7:0]       seed_r;
    logic [7:0]       cur_byte;
    logic             tx_on, er_nxt;
    logic             crc_init, crc_en;
    logic [31:0]      crc_out;
    logic             accept, adv;

    assign busy   = (state != ST_IDLE);
    assign accept = start && !busy && (frm_len != '0) && (frm_num != '0);
    // A byte time ends every cycle in GMII, every second cycle in MII.
    assign adv    = (mode_r == MODE_GMII) || nib;

    mac_crc32_d8 u_crc (
        .Tx_clk  (Tx_clk),
        .reset   (reset),
        .init    (crc_init),
        .en      (crc_en),
        .data    (cur_byte),
        .crc_out (crc_out)
    );

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        frm_cnt_nxt = frm_cnt;
        done_nxt    = 1'b0;
        cur_byte    = 8'h00;
        tx_on       = 1'b0;
        crc_init    = 1'b0;
        crc_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt   = ST_PRE;
                    cnt_nxt     = '0;
                    frm_cnt_nxt = '0;
                end
            end
            ST_PRE: begin
                cur_byte = PREAMBLE_BYTE;
                tx_on    = 1'b1;
                if (adv) begin
                    if (cnt == LEN_W'(PRE_BYTES - 1)) begin
                        state_nxt = ST_SFD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + LEN_W'(1);
                    end
                end
            end
            ST_SFD: begin
                cur_byte = SFD_BYTE;
                tx_on    = 1'b1;
                crc_init = 1'b1;
                if (adv) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                cur_byte = seed_r + cnt[7:0];
                tx_on    = 1'b1;
                crc_en   = adv;
                if (adv) begin
                    if (cnt == len_r - LEN_W'(1)) begin
                        state_nxt = ST_FCS;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + LEN_W'(1);
                    end
                end
            end
            ST_FCS: begin
                cur_byte = crc_out[{cnt[1:0], 3'b000} +: 8];
                tx_on    = 1'b1;
                if (adv) begin
                    if (cnt[1:0] == 2'd3) begin
                        state_nxt   = ST_IFG;
                        cnt_nxt     = '0;
                        frm_cnt_nxt = frm_cnt + LEN_W'(1);
                    end else begin
                        cnt_nxt = cnt + LEN_W'(1);
                    end
                end
            end
            ST_IFG: begin
                if (adv) begin
                    if (cnt == LEN_W'(IFG_BYTES - 1)) begin
                        cnt_nxt = '0;
                        if (frm_cnt == num_r) begin
                            state_nxt = ST_IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_PRE;
                        end
                    end else begin
                        cnt_nxt = cnt + LEN_W'(1);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Tx_clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            nib     <= 1'b0;
            frm_cnt <= '0;
            done    <= 1'b0;
            mode_r  <= MODE_MII;
            len_r   <= '0;
            num_r   <= '0;
            seed_r  <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            frm_cnt <= frm_cnt_nxt;
            done    <= done_nxt;
            nib     <= (state != ST_IDLE) && (mode_r == MODE_MII) && !nib;
            if (accept) begin
                mode_r <= mode;
                len_r  <= frm_len;
                num_r  <= frm_num;
                seed_r <= pat_seed;
            end
        end
    end

`ifdef MII_GEN_ERR_INJ_EN
    logic             err_r;
    logic [LEN_W-1:0] errp_r;

    always_ff @(posedge Tx_clk or posedge reset) begin
        if (reset) begin
            err_r  <= 1'b0;
            errp_r <= '0;
        end else if (accept) begin
            err_r  <= err_inj;
            errp_r <= err_pos;
        end
    end

    // An err_pos beyond the payload never matches cnt, so nothing is flagged.
    assign er_nxt = err_r && (state == ST_DATA) && (cnt == errp_r);
`else
    assign er_nxt = 1'b0;
`endif

    // Wire outputs lag the state by one cycle; MII sends the low nibble first.
    always_ff @(posedge Tx_clk or posedge reset) begin
        if (reset) begin
            Tx_en <= 1'b0;
            Tx_er <= 1'b0;
            Txd   <= 8'h00;
        end else begin
            Tx_en <= tx_on;
            Tx_er <= er_nxt;
            Txd   <= (mode_r == MODE_GMII) ? cur_byte
                   : {4'h0, (nib ? cur_byte[7:4] : cur_byte[3:0])};
        end
    end

endmodule

// File: tb/tb_mii_frame_gen.sv
// Self-checking bench for mii_frame_gen: vector table of bursts, byte scoreboard
// fed by the driver and drained by a wire monitor, plus reset/ignore corner cases.
`timescale 1ns/1ps
module tb_mii_frame_gen;
    import mii_gen_defs::*;

    localparam int LEN_W = 16;
    localparam int PRE   = 7;

    logic             Tx_clk = 1'b0;
    logic             reset;
    logic             mode;
    logic             start;
    logic [LEN_W-1:0] frm_len;
    logic [LEN_W-1:0] frm_num;
    logic [7:0]       pat_seed;
`ifdef MII_GEN_ERR_INJ_EN
    logic             err_inj;
    logic [LEN_W-1:0] err_pos;
`endif
    logic             Tx_en;
    logic             Tx_er;
    logic [7:0]       Txd;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] frm_cnt;

    always #4 Tx_clk = ~Tx_clk;

    mii_frame_gen #(.IFG_BYTES(12), .PRE_BYTES(PRE), .LEN_W(LEN_W)) dut (
        .Tx_clk   (Tx_clk),
        .reset    (reset),
        .mode     (mode),
        .start    (start),
        .frm_len  (frm_len),
        .frm_num  (frm_num),
        .pat_seed (pat_seed),
`ifdef MII_GEN_ERR_INJ_EN
        .err_inj  (err_inj),
        .err_pos  (err_pos),
`endif
        .Tx_en    (Tx_en),
        .Tx_er    (Tx_er),
        .Txd      (Txd),
        .busy     (busy),
        .done     (done),
        .frm_cnt  (frm_cnt)
    );

    typedef struct {
        logic [7:0] d;
        logic       er;
    } exp_t;

    typedef struct {
        logic        m;
        int          len;
        int          num;
        logic [7:0]  seed;
        logic [31:0] fcs;   // 0 means take it from the reference model
        int          hi;    // Tx_en-high cycles per frame
        int          gap;   // idle cycles between frames / before done
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic mon_mode = MODE_GMII;
    int   exp_hi = 0, exp_gap = 0;
    int   hi_cnt = 0, lo_run = 0, last_hi = 0, frames_seen = 0;
    bit   in_frame = 0, gap_armed = 0, nib_ph = 0;
    logic [3:0] lo_nib;
    logic       lo_er;

    always @(posedge Tx_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Serial MSB-first CRC over bit-reversed input, reflected and complemented at the end.
    function automatic logic [31:0] ref_fcs(input logic [7:0] seed, input int len);
        logic [31:0] c, r;
        logic [7:0]  b;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < len; k++) begin
            b = seed + 8'(k);
            for (int i = 0; i < 8; i++) begin
                fb = b[i] ^ c[31];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04C11DB7;
            end
        end
        for (int i = 0; i < 32; i++) r[i] = c[31-i];
        return ~r;
    endfunction

    task automatic pop_cmp(input logic [7:0] d, input logic er);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%0h required=none (cycle %0d)", d, cyc);
        end else begin
            e = exp_q.pop_front();
            check("txd_byte", d, e.d);
            check("tx_er", er, e.er);
        end
    endtask

    always @(negedge Tx_clk) begin
        if (reset) begin
            in_frame  = 0;
            gap_armed = 0;
            nib_ph    = 0;
            hi_cnt    = 0;
        end else if (Tx_en) begin
            if (!in_frame) begin
                if (gap_armed) check("ifg_gap", lo_run, exp_gap);
                in_frame = 1;
                hi_cnt   = 0;
                nib_ph   = 0;
            end
            hi_cnt++;
            last_hi = cyc;
            if (mon_mode == MODE_GMII) begin
                pop_cmp(Txd, Tx_er);
            end else begin
                check("mii_txd_hi", Txd[7:4], 0);
                if (!nib_ph) begin
                    lo_nib = Txd[3:0];
                    lo_er  = Tx_er;
                    nib_ph = 1;
                end else begin
                    check("mii_er_pair", Tx_er, lo_er);
                    pop_cmp({Txd[3:0], lo_nib}, Tx_er);
                    nib_ph = 0;
                end
            end
        end else begin
            if (in_frame) begin
                in_frame = 0;
                frames_seen++;
                check("frame_en_cycles", hi_cnt, exp_hi);
                check("frm_cnt_step", frm_cnt, frames_seen);
                gap_armed = 1;
                lo_run    = 0;
            end
            lo_run++;
            check("idle_txd", Txd, 0);
        end
    end

    task automatic push_frames(input vec_t v, input logic [31:0] fcs, input logic ei, input int ep);
        exp_t e;
        for (int f = 0; f < v.num; f++) begin
            for (int i = 0; i < PRE; i++) begin
                e.d = 8'h55; e.er = 1'b0; exp_q.push_back(e);
            end
            e.d = 8'hD5; e.er = 1'b0; exp_q.push_back(e);
            for (int k = 0; k < v.len; k++) begin
                e.d = v.seed + 8'(k); e.er = ei && (k == ep); exp_q.push_back(e);
            end
            for (int i = 0; i < 4; i++) begin
                e.d = fcs[8*i +: 8]; e.er = 1'b0; exp_q.push_back(e);
            end
        end
    endtask

    task automatic drive_start(input vec_t v, input logic ei, input int ep);
        mode     = v.m;
        frm_len  = LEN_W'(v.len);
        frm_num  = LEN_W'(v.num);
        pat_seed = v.seed;
`ifdef MII_GEN_ERR_INJ_EN
        err_inj  = ei;
        err_pos  = LEN_W'(ep);
`else
        if (ei && ep < 0) $display("note: error injection not built");
`endif
        start = 1'b1;
        @(negedge Tx_clk);
        start = 1'b0;
    endtask

    task automatic run_burst(input vec_t v, input logic ei, input int ep, input bit back);
        logic [31:0] fcs;
        int got, extra;
        fcs = (v.fcs != 0) ? v.fcs : ref_fcs(v.seed, v.len);
        mon_mode = v.m; exp_hi = v.hi; exp_gap = v.gap;
        frames_seen = 0; gap_armed = 0;
        push_frames(v, fcs, ei, ep);
        @(negedge Tx_clk);
        drive_start(v, ei, ep);
        check("busy_after_start", busy, 1);
        check("txen_before_pre", Tx_en, 0);
        check("frm_cnt_cleared", frm_cnt, 0);
        @(negedge Tx_clk);
        check("first_pre_en", Tx_en, 1);
        check("first_pre_txd", Txd, (v.m == MODE_GMII) ? 8'h55 : 8'h05);
        // Inputs changed and a second start while busy must all be ignored.
        mode = ~v.m; frm_len = 16'd5; frm_num = 16'd7; pat_seed = ~v.seed; start = 1'b1;
        @(negedge Tx_clk);
        start = 1'b0;
        for (int rep = 0; rep < (back ? 2 : 1); rep++) begin
            got = 0;
            for (int t = 0; t < 8000; t++) begin
                if (done) begin got = 1; break; end
                @(negedge Tx_clk);
            end
            check("done_seen", got, 1);
            if (got == 0) break;
            check("done_after_ifg", cyc - last_hi, v.gap);
            check("busy_low_at_done", busy, 0);
            check("frm_cnt_final", frm_cnt, v.num);
            check("queue_drained", exp_q.size(), 0);
            if (back && rep == 0) begin
                frames_seen = 0; gap_armed = 0;
                push_frames(v, fcs, ei, ep);
                drive_start(v, ei, ep);
                check("start_in_done_cycle", busy, 1);
            end
        end
        extra = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge Tx_clk);
            if (done) extra++;
        end
        check("done_single", extra, 0);
        check("frm_cnt_held", frm_cnt, v.num);
    endtask

    task automatic ignored_start(input int len, input int num);
        logic [LEN_W-1:0] prev;
        int act;
        prev = frm_cnt;
        act  = 0;
        @(negedge Tx_clk);
        mode = MODE_GMII; frm_len = LEN_W'(len); frm_num = LEN_W'(num); pat_seed = 8'h31;
        start = 1'b1;
        @(negedge Tx_clk);
        start = 1'b0;
        for (int t = 0; t < 16; t++) begin
            if (busy || Tx_en || done) act++;
            @(negedge Tx_clk);
        end
        check("ignored_start_activity", act, 0);
        check("ignored_start_frm_cnt", frm_cnt, prev);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[5];
        vec_t v9;
        int   found;
        vt[0] = '{MODE_GMII, 9,   1, 8'h31, 32'hCBF43926, 21,  12};
        vt[1] = '{MODE_MII,  9,   1, 8'h31, 32'hCBF43926, 42,  24};
        vt[2] = '{MODE_GMII, 4,   3, 8'h00, 32'h0,        16,  12};
        vt[3] = '{MODE_MII,  1,   2, 8'hFF, 32'h0,        26,  24};
        vt[4] = '{MODE_GMII, 300, 1, 8'hF0, 32'h0,        312, 12};

        reset = 1'b1; start = 1'b0; mode = MODE_GMII;
        frm_len = '0; frm_num = '0; pat_seed = '0;
`ifdef MII_GEN_ERR_INJ_EN
        err_inj = 1'b0; err_pos = '0;
`endif
        repeat (3) @(negedge Tx_clk);
        check("rst_tx_en", Tx_en, 0);
        check("rst_tx_er", Tx_er, 0);
        check("rst_txd", Txd, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_frm_cnt", frm_cnt, 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_burst(vt[i], 1'b0, 0, (i == 0));

        ignored_start(0, 1);
        ignored_start(5, 0);

        // Reset in the middle of the payload, then a clean frame afterwards.
        v9 = vt[0];
        mon_mode = MODE_GMII; exp_hi = v9.hi; exp_gap = v9.gap;
        frames_seen = 0; gap_armed = 0;
        push_frames(v9, v9.fcs, 1'b0, 0);
        @(negedge Tx_clk);
        drive_start(v9, 1'b0, 0);
        found = 0;
        for (int t = 0; t < 100; t++) begin
            if (Tx_en && Txd == 8'h33) begin found = 1; break; end
            @(negedge Tx_clk);
        end
        check("reached_data_byte2", found, 1);
        #1 reset = 1'b1;
        #1;
        check("midrst_tx_en", Tx_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_txd", Txd, 0);
        check("midrst_frm_cnt", frm_cnt, 0);
        exp_q.delete();
        @(negedge Tx_clk);
        @(negedge Tx_clk);
        reset = 1'b0;
        run_burst(v9, 1'b0, 0, 1'b0);

`ifdef MII_GEN_ERR_INJ_EN
        run_burst(v9, 1'b1, 3, 1'b0);
        run_burst(v9, 1'b1, 9, 1'b0);
        run_burst(vt[1], 1'b1, 0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
